seq_scan_ctrl: RTL
==================

# seq_scan_ctrl

Frame-level controller for the serial 01010 pattern detector. Accepts a frame of bytes over a valid/ready handshake, serialises each byte MSB-first into an embedded overlapping Moore detector (one bit per clock), and counts pattern hits over the frame. When the frame is drained it reports a saturating match count and pulses `done`. It sits between a byte-wide producer and the bit-serial detection path, and sequences and configures that path.

## Interface
Parameters:
- `PATTERN`, default `5'b01010`: target sequence; the first-received bit is the MSB.
- `CNT_W`, default 8: width of the match counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle frame start request. Honoured only in IDLE.
- `frame_len`  in  8  number of bytes in the frame. Sampled when `start` is accepted.
- `in_valid`  in  1  producer has a byte.
- `in_data`  in  8  byte to scan.
- `in_ready`  out  1  controller accepts a byte this cycle.
- `bit_x`  out  1  serial bit currently presented to the detector (debug).
- `busy`  out  1  high from `start` acceptance until `done`, inclusive.
- `done`  out  1  one-cycle pulse when the frame is complete.
- `match_count`  out  CNT_W  hits in the last or current frame.
- `overflow`  out  1  sticky flag; the counter saturated in this frame.

## Operation
- **Reset values:** all outputs 0, state IDLE, detector history cleared.
- **States:** IDLE, LOAD, SHIFT, DRAIN, DONE.
- **IDLE:**
  - On `start` with `frame_len != 0`: latch `bytes_left = frame_len`, clear `match_count`, `overflow` and detector history; go to LOAD.
  - On `start` with `frame_len == 0`: clear count, go straight to DONE.
  - `start` outside IDLE is ignored.
- **LOAD:**
  - `in_ready = 1`.
  - On `in_valid && in_ready`: load `in_data` into the shift register, set `bit_idx = 7`, go to SHIFT.
  - With no `in_valid`, stay in LOAD indefinitely.
- **SHIFT:**
  - `bit_x = shreg[7]`, `bit_en = 1`; the shift register moves left one bit per cycle, for 8 cycles.
  - After the 8th bit, decrement `bytes_left`. Next state is LOAD if `bytes_left` is still nonzero, otherwise DRAIN.
- **DRAIN:** exactly one cycle, so the hit from the final bit is counted. Then go to DONE.
- **DONE:** `done = 1` for one cycle, then IDLE. `match_count` and `overflow` hold until the next accepted `start`.
- **Detector behaviour:**
  - Overlapping detection: after a hit it keeps the longest proper suffix that is also a prefix.
  - Advances only when `bit_en = 1`.
  - History persists across byte boundaries within a frame and is cleared at frame start.
- **Counter:** increments on each detector hit and saturates at 2^CNT_W − 1. An attempted increment at the maximum sets `overflow`.
- **Outside SHIFT:** `bit_x = 0` in every other state.
- **Reset mid-frame:** asynchronous abort to IDLE. All outputs return to 0 and the partial count is discarded.

## Timing
- Throughput: 9 cycles per byte minimum (1 LOAD + 8 SHIFT). There is no overlap of load and shift.
- Start latency: `start` sampled at edge N puts the controller in LOAD from cycle N+1, so `in_ready` is high in cycle N+1.
- Detector hit is a registered one-cycle pulse. It is asserted the cycle after the completing bit is on `bit_x`.
- `match_count` includes that hit one cycle later. It is final when `done` is high.
- Frame latency with zero producer stall: 9·L + 2 cycles from the first LOAD cycle to `done`.
- `busy` = (state ≠ IDLE).

## Structure
- Package `seq_scan_pkg`:
  - state enum (IDLE, LOAD, SHIFT, DRAIN, DONE);
  - default `PATTERN` and pattern length constant (5).
- Sub-module `pattern_det`:
  - ports: `clk`, `rst_n`, `clr`, `bit_en`, `x`, `hit`;
  - Moore FSM with 6 states (S0–S4 prefix lengths, S5 match);
  - `hit` registered, one cycle per completed match.
- Top level `seq_scan_ctrl`: the control FSM, shift register, byte/bit counters and the saturating counter.

## Test plan
- **Reset and idle:** after reset, all outputs are 0. `in_valid = 1` with no `start` gives `in_ready = 0` and no state change.
- **Single byte:** `frame_len = 1`, byte 0x0A → `match_count = 1` at `done`. `done` arrives 11 cycles after the first LOAD cycle.
- **Overlap across a byte boundary:** `frame_len = 2`, bytes 0x2A, 0xA0 → `match_count = 4`. Also run with `in_valid` stalls of 3 cycles between bytes; the count must be unchanged.
- **History cleared between frames:** frame A = {0x01} gives 0. Frame B = {0x40} also gives 0, not 1. Single byte 0x55 gives 2.
- **Saturation (CNT_W = 2):** `frame_len = 3`, bytes 0x55 ×3 → `match_count = 3`, `overflow = 1`. The next frame clears `overflow`.
- **Edge cases:**
  - `frame_len = 0` → `done` 2 cycles after `start` with count 0.
  - `start` while busy → ignored.
  - `rst_n` low mid-SHIFT → immediate (asynchronous) return to reset values; the next frame runs normally.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the frame-level 01010 scan controller.
package seq_scan_pkg;

  localparam int PAT_LEN = 5;
  localparam logic [PAT_LEN-1:0] DEF_PATTERN = 5'b01010;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, DONE} state_e;

  // Detector states: S0..S4 = matched prefix length, S5 = full match.
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} det_state_e;

endpackage

// File: rtl/pattern_det.sv
// Overlapping Moore detector for a PAT_LEN-bit serial pattern, first bit = MSB.
module pattern_det
  import seq_scan_pkg::*;
#(
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic bit_en,
  input  logic x,
  output logic hit
);

  det_state_e state_q, state_d;
  logic       hit_q, hit_d;

  function automatic logic pat_bit(input int i);
    logic [PAT_LEN-1:0] sh;
    if (i < 0 || i >= PAT_LEN) return 1'b0;
    sh = PATTERN >> (PAT_LEN - 1 - i);
    return sh[0];
  endfunction

  // Longest suffix of (matched prefix + new bit) that is also a prefix;
  // from S5 the history is the whole pattern, which gives the overlap.
  function automatic det_state_e next_state(input det_state_e s, input logic b);
    int   k, best, m;
    logic ok, sb;
    k    = int'(s);
    best = 0;
    for (int l = 1; l <= PAT_LEN; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          m  = k + 1 - l + j;
          sb = (m == k) ? b : pat_bit(m);
          if (sb != pat_bit(j)) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return det_state_e'(best[2:0]);
  endfunction

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    if (clr) begin
      state_d = S0;
    end else if (bit_en) begin
      state_d = next_state(state_q, x);
      hit_d   = (state_d == S5);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: accepts bytes, serialises them MSB-first into pattern_det,
// and reports a saturating hit count per frame.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       frame_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             bit_x,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [7:0]       bytes_left_q, bytes_left_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   inc;
  logic             det_clr, bit_en, hit;

  // Returns {attempted_past_max, next_value}.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return {1'b1, c};
    return {1'b0, c + 1'b1};
  endfunction

  pattern_det #(.PATTERN(PATTERN)) u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (det_clr),
    .bit_en(bit_en),
    .x     (bit_x),
    .hit   (hit)
  );

  always_comb begin
    state_d      = state_q;
    bytes_left_d = bytes_left_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    det_clr      = 1'b0;
    bit_en       = 1'b0;
    in_ready     = 1'b0;
    bit_x        = 1'b0;
    done         = 1'b0;
    inc          = sat_inc(cnt_q);

    // Hits arrive one cycle after their bit, so they may land in LOAD or DRAIN.
    if (hit) begin
      cnt_d = inc[CNT_W-1:0];
      ovf_d = ovf_q | inc[CNT_W];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          det_clr = 1'b1;
          if (frame_len != 8'd0) begin
            bytes_left_d = frame_len;
            state_d      = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d   = in_data;
          bit_idx_d = 3'd7;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bit_x     = shreg_q[7];
        bit_en    = 1'b1;
        shreg_d   = {shreg_q[6:0], 1'b0};
        bit_idx_d = bit_idx_q - 3'd1;
        if (bit_idx_q == 3'd0) begin
          bytes_left_d = bytes_left_q - 8'd1;
          state_d      = (bytes_left_q == 8'd1) ? DRAIN : LOAD;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bytes_left_q <= 8'd0;
      bit_idx_q    <= 3'd0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      bit_idx_q    <= bit_idx_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  // Shift data is only observed in SHIFT, after a load, so it needs no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign busy        = (state_q != IDLE);
  assign match_count = cnt_q;
  assign overflow    = ovf_q;

endmodule
